// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

  localparam int unsigned RegAddrWidthDefault = 5;
  localparam int unsigned MemTimeoutDefault   = 16;
  localparam int unsigned CntWidthDefault     = 16;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_TRAP     = 2'd2;

  typedef enum logic [1:0] {
    StRun     = ST_RUN,
    StMemWait = ST_MEM_WAIT,
    StTrap    = ST_TRAP
  } ctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use hazard comparator between the ID and EX stages.
module pipeline_ctrl_hazard_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned RegAddrWidth = RegAddrWidthDefault
) (
  input  logic [RegAddrWidth-1:0] rs1_i,
  input  logic [RegAddrWidth-1:0] rs2_i,
  input  logic [RegAddrWidth-1:0] rd_i,
  input  logic                    mem_read_i,
  output logic                    load_use_o
);

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign load_use_o = mem_read_i && (rd_i != '0) && ((rd_i == rs1_i) || (rd_i == rs2_i));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory wait FSM, hazard
// priority muxing, timeout trap and saturating stall-cycle counter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = RegAddrWidthDefault,
  parameter int unsigned MEM_TIMEOUT    = MemTimeoutDefault,
  parameter int unsigned CNT_WIDTH      = CntWidthDefault
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
  input  logic                      ID_EX_mem_read,
  input  logic                      EX_branch_taken,
  input  logic                      EX_MEM_mem_access,
  input  logic                      dmem_ack,
  output logic                      pc_en,
  output logic                      IF_ID_en,
  output logic                      ID_EX_en,
  output logic                      EX_MEM_en,
  output logic                      MEM_WB_en,
  output logic                      IF_ID_flush,
  output logic                      ID_EX_flush,
  output logic                      EX_MEM_flush,
  output logic                      MEM_WB_flush,
  output logic                      dmem_req,
  output logic                      mem_err,
  output logic [CNT_WIDTH-1:0]      stall_cnt
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

  ctrl_state_e          state_q, state_d;
  logic [WaitW-1:0]     wait_cnt_q, wait_cnt_d;
  logic                 mem_err_q, mem_err_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic mem_stall;

  pipeline_ctrl_hazard_detect #(
    .RegAddrWidth(REG_ADDR_WIDTH)
  ) u_hazard_detect (
    .rs1_i      (IF_ID_rs1),
    .rs2_i      (IF_ID_rs2),
    .rd_i       (ID_EX_rd),
    .mem_read_i (ID_EX_mem_read),
    .load_use_o (load_use)
  );

  always_comb begin
    mem_stall = 1'b0;
    unique case (state_q)
      StRun:     mem_stall = EX_MEM_mem_access && !dmem_ack;
      StMemWait: mem_stall = !dmem_ack;
      default:   mem_stall = 1'b0;
    endcase
  end

  // Output muxing: reset, trap, memory stall, branch, load-use in priority order.
  always_comb begin
    pc_en        = 1'b1;
    IF_ID_en     = 1'b1;
    ID_EX_en     = 1'b1;
    EX_MEM_en    = 1'b1;
    MEM_WB_en    = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_flush = 1'b0;
    MEM_WB_flush = 1'b0;
    dmem_req     = EX_MEM_mem_access;
    if (!reset_n) begin
      {pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en}     = '0;
      {IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush} = '1;
      dmem_req = 1'b0;
    end else if (state_q == StTrap) begin
      {pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en} = '0;
      dmem_req = 1'b0;
    end else if (mem_stall) begin
      {pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en} = '0;
      MEM_WB_flush = 1'b1;
    end else if (EX_branch_taken) begin
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      IF_ID_en    = 1'b0;
      ID_EX_flush = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_err_d   = mem_err_q;
    stall_cnt_d = stall_cnt_q;
    unique case (state_q)
      StRun: begin
        if (EX_MEM_mem_access && !dmem_ack) begin
          state_d    = StMemWait;
          wait_cnt_d = WaitW'(1);
        end
      end
      StMemWait: begin
        if (dmem_ack) begin
          state_d    = StRun;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WaitLast) begin
          state_d   = StTrap;
          mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = StTrap;
    endcase
    if (!pc_en && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StRun;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with a queue-based expected-result scoreboard.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] if_id_rs1 = '0, if_id_rs2 = '0, id_ex_rd = '0;
  logic       id_ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
  logic       ex_mem_mem_access = 1'b0, dmem_ack = 1'b0;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic       dmem_req, mem_err;
  logic [15:0] stall_cnt;

  typedef struct packed {
    logic [4:0]  en;   // {pc, IF_ID, ID_EX, EX_MEM, MEM_WB}
    logic [3:0]  fl;   // {IF_ID, ID_EX, EX_MEM, MEM_WB}
    logic        req;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  logic [15:0] exp_stall = '0;
  logic        exp_err = 1'b0;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .REG_ADDR_WIDTH(5),
    .MEM_TIMEOUT   (16),
    .CNT_WIDTH     (16)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .IF_ID_rs1         (if_id_rs1),
    .IF_ID_rs2         (if_id_rs2),
    .ID_EX_rd          (id_ex_rd),
    .ID_EX_mem_read    (id_ex_mem_read),
    .EX_branch_taken   (ex_branch_taken),
    .EX_MEM_mem_access (ex_mem_mem_access),
    .dmem_ack          (dmem_ack),
    .pc_en             (pc_en),
    .IF_ID_en          (if_id_en),
    .ID_EX_en          (id_ex_en),
    .EX_MEM_en         (ex_mem_en),
    .MEM_WB_en         (mem_wb_en),
    .IF_ID_flush       (if_id_flush),
    .ID_EX_flush       (id_ex_flush),
    .EX_MEM_flush      (ex_mem_flush),
    .MEM_WB_flush      (mem_wb_flush),
    .dmem_req          (dmem_req),
    .mem_err           (mem_err),
    .stall_cnt         (stall_cnt)
  );

  // One clock cycle: drive inputs, record expectation, check at negedge, advance.
  task automatic cyc(input string tag, input logic rn,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic mr, input logic br, input logic acc, input logic ack,
                     input logic [4:0] en, input logic [3:0] fl, input logic req);
    exp_t e;
    exp_t got;
    reset_n = rn;
    if_id_rs1 = rs1; if_id_rs2 = rs2; id_ex_rd = rd;
    id_ex_mem_read = mr; ex_branch_taken = br;
    ex_mem_mem_access = acc; dmem_ack = ack;
    if (!rn) begin
      exp_stall = '0;
      exp_err = 1'b0;
    end
    exp_q.push_back('{en: en, fl: fl, req: req, err: exp_err, cnt: exp_stall});
    @(negedge clk);
    e = exp_q.pop_front();
    got.en  = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
    got.fl  = {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
    got.req = dmem_req;
    got.err = mem_err;
    got.cnt = stall_cnt;
    total++;
    assert ({got.en, got.fl, got.req} === {e.en, e.fl, e.req}) else begin
      bad++;
      $error("FAIL %s ctl: got en=%b fl=%b req=%b want en=%b fl=%b req=%b",
             tag, got.en, got.fl, got.req, e.en, e.fl, e.req);
    end
    total++;
    assert (got.err === e.err) else begin
      bad++;
      $error("FAIL %s mem_err: got %b want %b", tag, got.err, e.err);
    end
    total++;
    assert (got.cnt === e.cnt) else begin
      bad++;
      $error("FAIL %s stall_cnt: got %0d want %0d", tag, got.cnt, e.cnt);
    end
    if (rn && !e.en[4]) exp_stall = exp_stall + 16'd1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset holds everything flushed and suppresses the request.
    cyc("reset", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 4'b1111, 1'b0);
    cyc("idle", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 4'b0000, 1'b0);
    // Load-use on rs2.
    cyc("ldu", 1'b1, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00111, 4'b0100, 1'b0);
    cyc("ldu_rs1", 1'b1, 5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00111, 4'b0100, 1'b0);
    cyc("ldu_x0", 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11111, 4'b0000, 1'b0);
    cyc("no_read", 1'b1, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 4'b0000, 1'b0);
    // Branch wins over load-use.
    cyc("br_ldu", 1'b1, 5'd5, 5'd3, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 5'b11111, 4'b1100, 1'b0);
    // Zero-wait memory access.
    cyc("mem0", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b11111, 4'b0000, 1'b1);
    cyc("mem0_run", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 4'b0000, 1'b0);
    // 3-cycle access with a held branch and hazard.
    for (int i = 0; i < 2; i++) begin
      cyc("mem3_wait", 1'b1, 5'd4, 5'd0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 5'b00000, 4'b0001, 1'b1);
    end
    cyc("mem3_ack", 1'b1, 5'd4, 5'd0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 5'b11111, 4'b1100, 1'b1);
    cyc("mem3_ldu", 1'b1, 5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00111, 4'b0100, 1'b0);
    // Ack on the 16th request cycle still succeeds.
    for (int i = 0; i < 15; i++) begin
      cyc("to_wait", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 4'b0001, 1'b1);
    end
    cyc("to_ack16", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b11111, 4'b0000, 1'b1);
    cyc("to_after", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 4'b0000, 1'b0);
    // Reset asserted mid-wait aborts the access.
    for (int i = 0; i < 3; i++) begin
      cyc("rw_wait", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 4'b0001, 1'b1);
    end
    cyc("rw_reset", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 4'b1111, 1'b0);
    // No ack and no access: only RUN shows all enables here.
    cyc("rw_run", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 4'b0000, 1'b0);
    // Timeout: 16 unacknowledged cycles trap on the 16th edge.
    for (int i = 0; i < 16; i++) begin
      cyc("tr_wait", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 4'b0001, 1'b1);
    end
    exp_err = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc("trap", 1'b1, 5'd3, 5'd0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 5'b00000, 4'b0000, 1'b0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
